design_switch_seq: RTL and testbench
====================================

Name: design_switch_seq

Overview:
Sequences changes of the 3-bit design-select that drives the shared pad mux of the misc design-selection macro. Replaces a raw, asynchronous design_sel with a safe switch sequence:
- hold the outgoing design in reset
- park the pads in the all-inputs default state
- present the new select while the design is still in reset
- release reset
The block sits between the select source (strap or management register) and the misc mux. Its outputs replace design_sel_buffered and the per-design rst_n gating.

Parameters:
HOLD_CYCLES, 16, cycles the old design is held in reset with its select still applied (≥1)
SAFE_CYCLES, 8, cycles with select forced to 0, all pads in default state (≥1)
SETTLE_CYCLES, 4, cycles the new select is applied with the design still in reset (≥1)
CNT_W, 8, phase counter width; every *_CYCLES must be ≤ 2^CNT_W
DEFAULT_SEL, 0, target select loaded on reset
MAX_SEL, 6, highest valid select code

Ports:
clk_i  in  1  system clock
rst  in  1  asynchronous active-high reset
sel_req  in  3  requested design select
sel_req_valid  in  1  request strobe
sel_req_ready  out  1  request can be accepted this cycle
ext_rst_n  in  1  external reset (io_in[0] AND rst_override_n), asynchronous to clk_i
design_sel_out  out  3  select to mux/designs
design_rst_n  out  1  active-low reset for the selected design
io_safe  out  1  pads must be in default (all-input) state
busy  out  1  switch sequence in progress
switch_done  out  1  one-cycle pulse on entering RUN
sel_err  out  1  one-cycle pulse on an accepted invalid request

Behaviour:
- Reset state (rst high, async):
  - state = SAFE; counter = SAFE_CYCLES-1; target = DEFAULT_SEL
  - design_sel_out = 0; design_rst_n = 0; io_safe = 1; busy = 1
  - switch_done = 0; sel_err = 0; sync flops = 0
- ext_rst_n passes through a 2-flop synchronizer (ext_sync). Synchronizer flops reset to 0 asynchronously.
- All outputs are registered. Outputs are decoded from the next state.
- States:
  - RUN: design_sel_out = target; design_rst_n = ext_sync; io_safe = 0; busy = 0; ready = 1.
  - PARK (target == 0): design_sel_out = 0; design_rst_n = 0; io_safe = 1; busy = 0; ready = 1.
  - DRAIN: design_sel_out = current (old) select; design_rst_n = 0; io_safe = 0; busy = 1; ready = 0. Lasts HOLD_CYCLES cycles.
  - SAFE: design_sel_out = 0; design_rst_n = 0; io_safe = 1; busy = 1; ready = 0. Lasts SAFE_CYCLES cycles.
  - LOAD: design_sel_out = target; design_rst_n = 0; io_safe = 0; busy = 1; ready = 0. Lasts SETTLE_CYCLES cycles.
- Transitions:
  - Accept = sel_req_valid & sel_req_ready, sampled at edge A.
  - Valid accepted request (sel_req ≤ MAX_SEL):
    - target ← sel_req
    - from RUN → DRAIN
    - from PARK → SAFE (DRAIN skipped: no running design)
  - DRAIN → SAFE → LOAD when the counter reaches 0. The counter reloads with the next phase length minus 1.
  - SAFE with target == 0 → PARK instead of LOAD.
  - LOAD → RUN; switch_done pulses in the first RUN cycle.
- Timing:
  - From RUN with ext_sync high, design_rst_n rises at edge A+HOLD+SAFE+SETTLE (28 with defaults).
  - From PARK, it rises at edge A+SAFE+SETTLE.
- Same-select request: accepted and runs the full sequence. Acts as a soft restart of the design.
- Invalid request (sel_req > MAX_SEL):
  - accepted (ready stays 1)
  - sel_err pulses at edge A+1
  - state, target and outputs unchanged
- While busy, sel_req_valid is ignored; there is no queueing. The requester must hold valid until ready.
- ext_rst_n low in RUN: design_rst_n falls 2–3 cycles later. State stays RUN and the select is unchanged.
- ext_rst_n is ignored in all states other than RUN. design_rst_n never rises outside RUN.
- rst asserted mid-sequence: immediate return to reset values. The sequence restarts toward DEFAULT_SEL; the old target is lost.
- Invariant: design_sel_out never changes in a cycle where design_rst_n = 1. Assert this in the bench.

Test Plan:
- Reset, DEFAULT_SEL=0, ext_rst_n=1 → io_safe=1, design_sel_out=0 through 8 cycles, then PARK; ready=1, design_rst_n=0.
- From PARK, request sel=3 → busy 1; design_sel_out=0 for 8 cycles, then 3; design_rst_n rises exactly 12 edges after accept; switch_done pulse in the same cycle.
- In RUN sel=3, request sel=5 → 16 cycles of sel=3 with rst_n=0; 8 cycles sel=0 with io_safe=1; 4 cycles sel=5 with rst_n=0; then rst_n=1. Check the invariant throughout.
- Request sel=7 in RUN → sel_err single pulse; sel/rst_n unchanged. Valid pulses while busy → ignored, target unchanged.
- In RUN, drop ext_rst_n for 5 cycles → design_rst_n low after 2–3 cycles for 5 cycles; no state change, no switch_done.
- Assert rst in the middle of DRAIN → next cycle: sel=0, io_safe=1, design_rst_n=0; sequence restarts toward DEFAULT_SEL.

Source files
------------

// File: rtl/design_switch_seq.sv
// design_switch_seq: sequences changes of the shared-pad design select so
// that the outgoing design is held in reset, the pads are parked in their
// all-input default state, the new select settles under reset, and only
// then is the new design released.

module design_switch_seq #(
  parameter int HOLD_CYCLES   = 16,
  parameter int SAFE_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8,
  parameter int DEFAULT_SEL   = 0,
  parameter int MAX_SEL       = 6
) (
  input  logic       clk_i,
  input  logic       rst,
  input  logic [2:0] sel_req,
  input  logic       sel_req_valid,
  output logic       sel_req_ready,
  input  logic       ext_rst_n,
  output logic [2:0] design_sel_out,
  output logic       design_rst_n,
  output logic       io_safe,
  output logic       busy,
  output logic       switch_done,
  output logic       sel_err
);

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_PARK  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_SAFE  = 3'd3,
    ST_LOAD  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAFE_LD   = CNT_W'(SAFE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       DEF_SEL   = 3'(DEFAULT_SEL);
  localparam logic [2:0]       MAX_CODE  = 3'(MAX_SEL);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       target_q, target_d;
  logic             err_pend_q, err_pend_d;
  logic [1:0]       ext_sync_q, ext_sync_d;
  logic [2:0]       design_sel_q, design_sel_d;
  logic             design_rst_n_q, design_rst_n_d;
  logic             io_safe_q, io_safe_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             switch_done_q, switch_done_d;
  logic             sel_err_q, sel_err_d;
  logic             accept;

  // Next-state, phase counter and target selection; outputs are decoded from the next state so they line up with it after the edge.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    target_d       = target_q;
    err_pend_d     = 1'b0;
    ext_sync_d     = {ext_sync_q[0], ext_rst_n};
    accept         = sel_req_valid & ready_q;

    case (state_q)
      ST_RUN, ST_PARK: begin
        if (accept) begin
          if (sel_req > MAX_CODE) begin
            err_pend_d = 1'b1;
          end else begin
            target_d = sel_req;
            if (state_q == ST_RUN) begin
              state_d = ST_DRAIN;
              cnt_d   = HOLD_LD;
            end else begin
              state_d = ST_SAFE;
              cnt_d   = SAFE_LD;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_SAFE;
          cnt_d   = SAFE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SAFE: begin
        if (cnt_q == '0) begin
          if (target_q == 3'd0) begin
            state_d = ST_PARK;
          end else begin
            state_d = ST_LOAD;
            cnt_d   = SETTLE_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_LOAD: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_SAFE;
        cnt_d   = SAFE_LD;
      end
    endcase

    design_sel_d   = 3'd0;
    design_rst_n_d = 1'b0;
    io_safe_d      = 1'b0;
    busy_d         = 1'b0;
    ready_d        = 1'b0;

    case (state_d)
      ST_RUN: begin
        design_sel_d   = target_d;
        design_rst_n_d = ext_sync_q[1];
        ready_d        = 1'b1;
      end
      ST_PARK: begin
        io_safe_d = 1'b1;
        ready_d   = 1'b1;
      end
      ST_DRAIN: begin
        design_sel_d = design_sel_q;
        busy_d       = 1'b1;
      end
      ST_SAFE: begin
        io_safe_d = 1'b1;
        busy_d    = 1'b1;
      end
      ST_LOAD: begin
        design_sel_d = target_d;
        busy_d       = 1'b1;
      end
      default: begin
        io_safe_d = 1'b1;
        busy_d    = 1'b1;
      end
    endcase

    switch_done_d = (state_d == ST_RUN) && (state_q != ST_RUN);
    // The invalid-request flag waits one extra stage so the pulse lands one edge after acceptance.
    sel_err_d     = err_pend_q;
  end

  // Two-flop synchronizer for the asynchronous external reset request.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      ext_sync_q <= 2'b00;
    end else begin
      ext_sync_q <= ext_sync_d;
    end
  end

  // Sequencer state plus all registered outputs; reset parks the pads and restarts toward the default select.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q        <= ST_SAFE;
      cnt_q          <= SAFE_LD;
      target_q       <= DEF_SEL;
      err_pend_q     <= 1'b0;
      design_sel_q   <= 3'd0;
      design_rst_n_q <= 1'b0;
      io_safe_q      <= 1'b1;
      busy_q         <= 1'b1;
      ready_q        <= 1'b0;
      switch_done_q  <= 1'b0;
      sel_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      target_q       <= target_d;
      err_pend_q     <= err_pend_d;
      design_sel_q   <= design_sel_d;
      design_rst_n_q <= design_rst_n_d;
      io_safe_q      <= io_safe_d;
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      switch_done_q  <= switch_done_d;
      sel_err_q      <= sel_err_d;
    end
  end

  assign sel_req_ready  = ready_q;
  assign design_sel_out = design_sel_q;
  assign design_rst_n   = design_rst_n_q;
  assign io_safe        = io_safe_q;
  assign busy           = busy_q;
  assign switch_done    = switch_done_q;
  assign sel_err        = sel_err_q;

endmodule

// File: tb/tb_design_switch_seq.sv
// tb_design_switch_seq: directed-vector bench for design_switch_seq with
// hand-computed expected output vectors and a select/reset invariant monitor.

module tb_design_switch_seq;

  logic       clk_i;
  logic       rst;
  logic [2:0] sel_req;
  logic       sel_req_valid;
  logic       sel_req_ready;
  logic       ext_rst_n;
  logic [2:0] design_sel_out;
  logic       design_rst_n;
  logic       io_safe;
  logic       busy;
  logic       switch_done;
  logic       sel_err;

  int assert_count = 0;
  int fail_count   = 0;

  design_switch_seq dut (
    .clk_i          (clk_i),
    .rst            (rst),
    .sel_req        (sel_req),
    .sel_req_valid  (sel_req_valid),
    .sel_req_ready  (sel_req_ready),
    .ext_rst_n      (ext_rst_n),
    .design_sel_out (design_sel_out),
    .design_rst_n   (design_rst_n),
    .io_safe        (io_safe),
    .busy           (busy),
    .switch_done    (switch_done),
    .sel_err        (sel_err)
  );

  // 10 ns free-running clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Packed observation: {sel[2:0], rst_n, io_safe, busy, ready, done, err}
  function automatic logic [8:0] observe();
    return {design_sel_out, design_rst_n, io_safe, busy, sel_req_ready, switch_done, sel_err};
  endfunction

  function automatic logic [8:0] mk(input logic [2:0] s, input logic rn, input logic sf,
                                    input logic bz, input logic rd, input logic dn, input logic er);
    return {s, rn, sf, bz, rd, dn, er};
  endfunction

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Invariant: the select must not move while the design is (or was just) out of reset
  logic [2:0] prev_sel;
  logic       prev_rst_n;
  logic       prev_ok = 1'b0;
  always @(negedge clk_i) begin
    if (prev_ok && (design_rst_n === 1'b1 || prev_rst_n === 1'b1)) begin
      assert_count++;
      if (design_sel_out !== prev_sel) begin
        fail_count++;
        $display("[TB] FAIL invariant_sel_stable t=%0t: sel=%0d, previous sel=%0d with rst_n high", $time, design_sel_out, prev_sel);
      end
    end
    prev_sel   <= design_sel_out;
    prev_rst_n <= design_rst_n;
    prev_ok    <= 1'b1;
  end

  task automatic test_reset();
    logic [8:0] exp;
    rst = 1'b1; ext_rst_n = 1'b1; sel_req_valid = 1'b0; sel_req = 3'd0;
    tick(); tick();
    exp = mk(3'd0, 0, 1, 1, 0, 0, 0);
    assert_count++;
    if (observe() !== exp) begin
      fail_count++;
      $display("[TB] FAIL reset_values: got %b, expected %b", observe(), exp);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k < 8) ? mk(3'd0, 0, 1, 1, 0, 0, 0) : mk(3'd0, 0, 1, 0, 1, 0, 0);
      assert_count++;
      if (observe() !== exp) begin
        fail_count++;
        $display("[TB] FAIL reset_safe_to_park k=%0d: got %b, expected %b", k, observe(), exp);
      end
    end
  endtask

  task automatic test_park_to_run(input logic [2:0] new_sel);
    logic [8:0] exp;
    sel_req = new_sel; sel_req_valid = 1'b1;
    tick();
    sel_req_valid = 1'b0;
    for (int j = 0; j < 12; j++) begin
      exp = (j < 8) ? mk(3'd0, 0, 1, 1, 0, 0, 0) : mk(new_sel, 0, 0, 1, 0, 0, 0);
      assert_count++;
      if (observe() !== exp) begin
        fail_count++;
        $display("[TB] FAIL park_to_run j=%0d: got %b, expected %b", j, observe(), exp);
      end
      tick();
    end
    exp = mk(new_sel, 1, 0, 0, 1, 1, 0);
    assert_count++;
    if (observe() !== exp) begin
      fail_count++;
      $display("[TB] FAIL park_to_run_release: got %b, expected %b", observe(), exp);
    end
    tick();
    exp = mk(new_sel, 1, 0, 0, 1, 0, 0);
    assert_count++;
    if (observe() !== exp) begin
      fail_count++;
      $display("[TB] FAIL park_to_run_done_single: got %b, expected %b", observe(), exp);
    end
  endtask

  task automatic test_run_to_run(input logic [2:0] old_sel, input logic [2:0] new_sel);
    logic [8:0] exp;
    sel_req = new_sel; sel_req_valid = 1'b1;
    tick();
    sel_req_valid = 1'b0;
    for (int j = 0; j < 28; j++) begin
      if (j < 16)      exp = mk(old_sel, 0, 0, 1, 0, 0, 0);
      else if (j < 24) exp = mk(3'd0,    0, 1, 1, 0, 0, 0);
      else             exp = mk(new_sel, 0, 0, 1, 0, 0, 0);
      assert_count++;
      if (observe() !== exp) begin
        fail_count++;
        $display("[TB] FAIL run_to_run %0d->%0d j=%0d: got %b, expected %b", old_sel, new_sel, j, observe(), exp);
      end
      tick();
    end
    exp = mk(new_sel, 1, 0, 0, 1, 1, 0);
    assert_count++;
    if (observe() !== exp) begin
      fail_count++;
      $display("[TB] FAIL run_to_run_release %0d->%0d: got %b, expected %b", old_sel, new_sel, observe(), exp);
    end
    tick();
  endtask

  task automatic test_invalid_sel(input logic [2:0] cur_sel);
    logic [8:0] exp;
    sel_req = 3'd7; sel_req_valid = 1'b1;
    tick();
    sel_req_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      exp = mk(cur_sel, 1, 0, 0, 1, 0, (j == 1));
      assert_count++;
      if (observe() !== exp) begin
        fail_count++;
        $display("[TB] FAIL invalid_sel j=%0d: got %b, expected %b", j, observe(), exp);
      end
      tick();
    end
  endtask

  task automatic test_busy_ignored(input logic [2:0] old_sel, input logic [2:0] new_sel);
    logic [8:0] exp;
    sel_req = new_sel; sel_req_valid = 1'b1;
    tick();
    sel_req = 3'd4;
    for (int j = 0; j < 28; j++) begin
      if (j == 20) sel_req_valid = 1'b0;
      assert_count++;
      if (sel_req_ready !== 1'b0 || busy !== 1'b1) begin
        fail_count++;
        $display("[TB] FAIL busy_ignored j=%0d: ready=%b busy=%b, expected ready=0 busy=1", j, sel_req_ready, busy);
      end
      tick();
    end
    exp = mk(new_sel, 1, 0, 0, 1, 1, 0);
    assert_count++;
    if (observe() !== exp) begin
      fail_count++;
      $display("[TB] FAIL busy_ignored_target %0d->%0d: got %b, expected %b", old_sel, new_sel, observe(), exp);
    end
    tick();
  endtask

  task automatic test_ext_reset(input logic [2:0] cur_sel);
    int low_cycles = 0;
    ext_rst_n = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 5) ext_rst_n = 1'b1;
      if (design_rst_n === 1'b0) low_cycles++;
      assert_count++;
      if (design_sel_out !== cur_sel || busy !== 1'b0 || switch_done !== 1'b0 || io_safe !== 1'b0) begin
        fail_count++;
        $display("[TB] FAIL ext_reset_state e=%0d: sel=%0d busy=%b done=%b io_safe=%b, expected sel=%0d busy=0 done=0 io_safe=0",
                 e, design_sel_out, busy, switch_done, io_safe, cur_sel);
      end
      if (e == 1) begin
        assert_count++;
        if (design_rst_n !== 1'b1) begin
          fail_count++;
          $display("[TB] FAIL ext_reset_too_early: rst_n=%b after 1 edge, expected 1", design_rst_n);
        end
      end
      if (e == 3) begin
        assert_count++;
        if (design_rst_n !== 1'b0) begin
          fail_count++;
          $display("[TB] FAIL ext_reset_late: rst_n=%b after 3 edges, expected 0", design_rst_n);
        end
      end
    end
    assert_count++;
    if (low_cycles != 5 || design_rst_n !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL ext_reset_duration: low %0d cycles final rst_n=%b, expected 5 cycles final 1", low_cycles, design_rst_n);
    end
  endtask

  task automatic test_reset_mid_drain(input logic [2:0] old_sel);
    logic [8:0] exp;
    sel_req = 3'd6; sel_req_valid = 1'b1;
    tick();
    sel_req_valid = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    exp = mk(old_sel, 0, 0, 1, 0, 0, 0);
    assert_count++;
    if (observe() !== exp) begin
      fail_count++;
      $display("[TB] FAIL mid_drain_pre: got %b, expected %b", observe(), exp);
    end
    rst = 1'b1;
    tick();
    exp = mk(3'd0, 0, 1, 1, 0, 0, 0);
    assert_count++;
    if (observe() !== exp) begin
      fail_count++;
      $display("[TB] FAIL mid_drain_reset: got %b, expected %b", observe(), exp);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k < 8) ? mk(3'd0, 0, 1, 1, 0, 0, 0) : mk(3'd0, 0, 1, 0, 1, 0, 0);
      assert_count++;
      if (observe() !== exp) begin
        fail_count++;
        $display("[TB] FAIL mid_drain_restart k=%0d: got %b, expected %b", k, observe(), exp);
      end
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence
  initial begin
    test_reset();
    test_park_to_run(3'd3);
    test_run_to_run(3'd3, 3'd5);
    test_run_to_run(3'd5, 3'd5);
    test_invalid_sel(3'd5);
    test_busy_ignored(3'd5, 3'd2);
    test_ext_reset(3'd2);
    test_reset_mid_drain(3'd2);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
